// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store path.
// Accepts a word-addressed access on the active-low strobe, holds it for a
// configurable number of wait states, performs the array access, then pulses
// rdy for one cycle with registered read data and an out-of-range flag.
//
// Handshake: the initiator drives as_ low with rw/addr/wr_data/wr_be stable
// at an edge where the responder is IDLE; that edge accepts the request and
// latches every input. rdy is high for exactly one cycle per accepted request.
// The initiator then has one full cycle to raise as_ or present the next
// request; an as_ still low at the next IDLE edge is a new access. rdy, err
// and rd_data come straight from flops, with no combinational input path.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        rdy,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched request and wait-state counter
  logic [3:0]            cnt;
  logic                  lat_rw;
  logic [29:0]           lat_addr;
  logic [31:0]           lat_wr_data;
  logic [3:0]            lat_be;

  // Word array; never reset, so it can map onto a RAM macro
  logic [31:0]           mem [DEPTH];

  // Decoded control strobes
  logic                  accept;
  logic                  access;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] idx;

  assign idx       = lat_addr[DEPTH_LOG2-1:0];
  assign fsm_state = state_q;

  // State register; reset aborts any request that has not yet reached RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: as_ is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!as_) state_d = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/control decode: acceptance, access edge, range check, enables
  always_comb begin
    accept   = 1'b0;
    access   = 1'b0;
    in_range = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    if (state_q == ST_IDLE && !as_) begin
      accept = 1'b1;
    end
    if (state_q == ST_WAIT && cnt == 4'd0) begin
      access = 1'b1;
    end
    // Upper address bits beyond the array must all be zero
    in_range = ((lat_addr >> DEPTH_LOG2) == '0);
    wr_en    = access && lat_rw && in_range;
    rd_en    = access && !lat_rw;
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 4'd0;
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
      lat_be      <= '0;
    end else if (accept) begin
      cnt         <= 4'(WAIT_CYCLES);
      lat_rw      <= rw;
      lat_addr    <= addr;
      lat_wr_data <= wr_data;
      lat_be      <= wr_be;
    end else if (state_q == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Byte-masked array write, committed on the WAIT->RESP edge only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[idx][8*i +: 8] <= lat_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Response registers: rdy/err live for the RESP cycle, rd_data holds
  // until the next completed read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy     <= 1'b0;
      err     <= 1'b0;
      rd_data <= 32'h0;
    end else begin
      rdy <= access;
      err <= access && !in_range;
      if (rd_en) begin
        rd_data <= in_range ? mem[idx] : 32'h0;
      end
    end
  end

endmodule
